adc_sar_ctrl: RTL

Digital successive-approximation controller for the generic SAR ADC analog model. It accepts a conversion request, waits for analog ready, and holds the sample switch for a programmable number of cycles. It then runs an N-step binary search on the DAC code using the comparator decision and delivers the result with a single-cycle end-of-conversion strobe. It sits between the digital ADC wrapper/register file and the analog macro; `clk` is the same clock routed to the macro's `ms_clk`.

---
 rtl/adc_sar_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adc_sar_ctrl.sv
// SAR ADC conversion controller.
// Takes a start request, waits for the analog macro to report ready, holds
// the sample switch for SAMPLE_CYCLES clocks, and then runs an N-step binary
// search on the DAC code using the comparator decision. The result is
// published with a one-cycle eoc strobe.
// Optional build macro ADC_SAR_CTRL_CONT_EN adds a `cont` input. With cont
// high, DONE goes straight back to SAMPLE so conversions run back to back.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; ms_dac parked at 0
// S_WAIT_RDY | start seen while the macro was not ready; waiting for ms_rdy
// S_SAMPLE   | sample switch closed; r_cnt counts down the remaining cycles
// S_CONV     | binary search; r_bit is the bit decided at the next edge
// S_DONE     | result on ms_dac/data, eoc high for this single cycle
module adc_sar_ctrl #(
  parameter int N             = 12,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ms_rdy,
  input  logic         ms_cmp,
`ifdef ADC_SAR_CTRL_CONT_EN
  input  logic         cont,
`endif
  output logic         ms_sample,
  output logic [N-1:0] ms_dac,
  output logic         busy,
  output logic         eoc,
  output logic [N-1:0] data,
  output logic         abort
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  LP_ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  LP_MSB      = LP_ONE << (N - 1);
  localparam logic [KW-1:0] LP_TOP      = KW'(N - 1);
  localparam logic [7:0]    LP_SMP_LAST = 8'(SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_SAMPLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [KW-1:0] r_bit;
  logic [N-1:0]  w_code;

  // Current trial code with the bit under test replaced by the comparator decision.
  always_comb begin
    w_code        = ms_dac;
    w_code[r_bit] = ms_cmp;
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      ms_sample <= 1'b0;
      ms_dac    <= '0;
      busy      <= 1'b0;
      eoc       <= 1'b0;
      data      <= '0;
      abort     <= 1'b0;
    end else begin
      eoc   <= 1'b0;
      abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (ms_rdy) begin
              r_state   <= S_SAMPLE;
              ms_sample <= 1'b1;
              r_cnt     <= LP_SMP_LAST;
            end else begin
              r_state <= S_WAIT_RDY;
            end
          end
        end
        S_WAIT_RDY: begin
          if (ms_rdy) begin
            r_state   <= S_SAMPLE;
            ms_sample <= 1'b1;
            r_cnt     <= LP_SMP_LAST;
          end
        end
        S_SAMPLE: begin
          if (!ms_rdy) begin
            r_state   <= S_IDLE;
            ms_sample <= 1'b0;
            ms_dac    <= '0;
            busy      <= 1'b0;
            abort     <= 1'b1;
          end else if (r_cnt == 8'd0) begin
            r_state   <= S_CONV;
            ms_sample <= 1'b0;
            ms_dac    <= LP_MSB;
            r_bit     <= LP_TOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CONV: begin
          if (!ms_rdy) begin
            r_state <= S_IDLE;
            ms_dac  <= '0;
            busy    <= 1'b0;
            abort   <= 1'b1;
          end else if (r_bit == '0) begin
            r_state <= S_DONE;
            ms_dac  <= w_code;
            data    <= w_code;
            eoc     <= 1'b1;
          end else begin
            ms_dac <= w_code | (LP_ONE << (r_bit - 1'b1));
            r_bit  <= r_bit - 1'b1;
          end
        end
        S_DONE: begin
`ifdef ADC_SAR_CTRL_CONT_EN
          if (cont) begin
            r_state   <= S_SAMPLE;
            ms_sample <= 1'b1;
            ms_dac    <= '0;
            r_cnt     <= LP_SMP_LAST;
          end else begin
            r_state <= S_IDLE;
            ms_dac  <= '0;
            busy    <= 1'b0;
          end
`else
          r_state <= S_IDLE;
          ms_dac  <= '0;
          busy    <= 1'b0;
`endif
        end
        default: begin
          r_state   <= S_IDLE;
          ms_sample <= 1'b0;
          ms_dac    <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
